// File: rtl/dds_sweep_writer_if.sv
// Host-side bundle between the sweep control bank, the sweep writer
// and the DDS register-write port (DATA/WE/A).
interface dds_sweep_writer_if #(
  parameter int DW = 28,
  parameter int AW = 5,
  parameter int CW = 16
);
  logic          START;
  logic          ABORT;
  logic [DW-1:0] F_START;
  logic [DW-1:0] F_STEP;
  logic [CW-1:0] N_STEPS;
  logic [CW-1:0] DWELL;
  logic [DW-1:0] P_OFF;
  logic [DW-1:0] DATA;
  logic          WE;
  logic [AW-1:0] A;
  logic          BUSY;
  logic          DONE;

  modport master (
    output START, ABORT, F_START, F_STEP,
    output N_STEPS, DWELL, P_OFF,
    input  DATA, WE, A, BUSY, DONE
  );

  modport slave (
    input  START, ABORT, F_START, F_STEP,
    input  N_STEPS, DWELL, P_OFF,
    output DATA, WE, A, BUSY, DONE
  );
endinterface

// File: rtl/dds_sweep_writer.sv
// Programs a linear frequency sweep into a DDS via its DATA/WE/A port.
// Define DDS_TRI_SWEEP_EN for a triangle (up then down) sweep.
module dds_sweep_writer #(
  parameter int DW        = 28,
  parameter int AW        = 5,
  parameter int PINC_ADDR = 0,
  parameter int POFF_ADDR = 1,
  parameter int CW        = 16
) (
  input logic CLK,
  input logic RST_N,
  dds_sweep_writer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_POFF,
    S_WR_PINC,
    S_DWELL,
    S_DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] cur;
  logic [DW-1:0] step;
  logic [CW-1:0] n_steps;
  logic [CW-1:0] dwell;
  logic [CW-1:0] step_cnt;
  logic [CW-1:0] dwell_cnt;
  logic [DW-1:0] data;
  logic          we;
  logic [AW-1:0] addr;
  logic          busy;
  logic          done;

  logic [DW-1:0] nxt;
  logic [CW-1:0] cnt_nxt;
  logic          last;

`ifdef DDS_TRI_SWEEP_EN
  logic down;
  logic turn;

  // turn marks the top of the up leg; the down leg reuses step_cnt from 1
  always_comb begin
    turn    = !down && (step_cnt == n_steps) && (n_steps != '0);
    last    = (step_cnt == n_steps) && !turn;
    nxt     = (down || turn) ? cur - step : cur + step;
    cnt_nxt = turn ? CW'(1) : step_cnt + CW'(1);
  end
`else
  always_comb begin
    last    = (step_cnt == n_steps);
    nxt     = cur + step;
    cnt_nxt = step_cnt + CW'(1);
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      cur       <= '0;
      step      <= '0;
      n_steps   <= '0;
      dwell     <= '0;
      step_cnt  <= '0;
      dwell_cnt <= '0;
      data      <= '0;
      we        <= 1'b0;
      addr      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef DDS_TRI_SWEEP_EN
      down      <= 1'b0;
`endif
    end else if (bus.ABORT) begin
      state <= S_IDLE;
      we    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.START) begin
            cur      <= bus.F_START;
            step     <= bus.F_STEP;
            n_steps  <= bus.N_STEPS;
            dwell    <= bus.DWELL;
            step_cnt <= '0;
            state    <= S_WR_POFF;
            we       <= 1'b1;
            addr     <= AW'(POFF_ADDR);
            data     <= bus.P_OFF;
            busy     <= 1'b1;
`ifdef DDS_TRI_SWEEP_EN
            down     <= 1'b0;
`endif
          end
        end
        S_WR_POFF: begin
          state <= S_WR_PINC;
          we    <= 1'b1;
          addr  <= AW'(PINC_ADDR);
          data  <= cur;
        end
        S_WR_PINC: begin
          state     <= S_DWELL;
          dwell_cnt <= CW'(1);
        end
        S_DWELL: begin
          // starting at 1 makes a DWELL of 0 behave as 1
          if (dwell_cnt >= dwell) begin
            if (last) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              cur      <= nxt;
              step_cnt <= cnt_nxt;
              state    <= S_WR_PINC;
              we       <= 1'b1;
              addr     <= AW'(PINC_ADDR);
              data     <= nxt;
`ifdef DDS_TRI_SWEEP_EN
              if (turn) down <= 1'b1;
`endif
            end
          end else begin
            dwell_cnt <= dwell_cnt + CW'(1);
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.DATA = data;
  assign bus.WE   = we;
  assign bus.A    = addr;
  assign bus.BUSY = busy;
  assign bus.DONE = done;

endmodule
